// File: rtl/prime_search_pkg.sv
// Shared types and helpers for the prime search controller.
package prime_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TEST,
    MOD_WAIT,
    NEXT_CAND,
    DONE
  } state_t;

  // A factor is squared against a candidate, so the product needs twice the width.
  function automatic int square_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/prime_search_ctrl_mod_iter.sv
// Restoring remainder unit: one quotient bit per cycle, result after exactly WIDTH cycles.
module mod_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] divreg;
  logic [CW-1:0]    count;
  logic             active;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try a subtraction.
  always_comb begin
    shifted = {rem, shreg[WIDTH-1]};
    trial   = shifted - {1'b0, divreg};
  end

  // Iterate for a fixed WIDTH steps; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      divreg <= '0;
      rem    <= '0;
      count  <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg  <= dividend;
        divreg <= divisor;
        rem    <= '0;
        count  <= CW'(WIDTH);
        active <= 1'b1;
      end else if (active) begin
        if (!trial[WIDTH]) begin
          rem <= trial[WIDTH-1:0];
        end else begin
          rem <= shifted[WIDTH-1:0];
        end
        shreg <= shreg << 1;
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prime_search_ctrl.sv
// Prime search controller: finds the smallest prime >= req_base by trial division.
// Optional feature macro PRIME_PAIR_EN: also require cand+OFFSET to be prime
// and report the lower member of the pair.
module prime_search_ctrl
  import prime_search_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int OFFSET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_base,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_prime,
  output logic             rsp_overflow,
  output logic             busy
);

  localparam int SQW = square_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] factor_q, factor_d;
  logic             ovf_q, ovf_d;
  logic             mod_start;
  logic [WIDTH-1:0] mod_dividend;
  logic             mod_done;
  logic [WIDTH-1:0] mod_rem;
  logic [SQW-1:0]   factor_sq;
  logic [SQW-1:0]   bound;
`ifdef PRIME_PAIR_EN
  logic             phase_q, phase_d;
  logic [WIDTH:0]   partner_wide;
  logic [WIDTH-1:0] cur_operand;
  logic             witness;
`endif

  mod_iter #(.WIDTH(WIDTH)) u_mod_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (mod_start),
    .dividend (mod_dividend),
    .divisor  (factor_q),
    .done     (mod_done),
    .rem      (mod_rem)
  );

  // Register the FSM state and the search datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      factor_q <= '0;
      ovf_q    <= 1'b0;
`ifdef PRIME_PAIR_EN
      phase_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      factor_q <= factor_d;
      ovf_q    <= ovf_d;
`ifdef PRIME_PAIR_EN
      phase_q  <= phase_d;
`endif
    end
  end

`ifdef PRIME_PAIR_EN
  // The partner sets the search bound; a factor equal to the operand is not a divisor witness.
  always_comb begin
    partner_wide = {1'b0, cand_q} + (WIDTH+1)'(OFFSET);
    cur_operand  = phase_q ? partner_wide[WIDTH-1:0] : cand_q;
    witness      = (mod_rem == '0) && (factor_q != cur_operand);
    factor_sq    = SQW'(factor_q) * SQW'(factor_q);
    bound        = SQW'(partner_wide);
  end
`else
  // Trial division stops once factor squared exceeds the candidate.
  always_comb begin
    factor_sq = SQW'(factor_q) * SQW'(factor_q);
    bound     = SQW'(cand_q);
  end
`endif

  // Next-state logic: accept, test factor bound, wait for remainder, advance candidate.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    factor_d     = factor_q;
    ovf_d        = ovf_q;
    mod_start    = 1'b0;
`ifdef PRIME_PAIR_EN
    phase_d      = phase_q;
    mod_dividend = cur_operand;
`else
    mod_dividend = cand_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cand_d   = (req_base < WIDTH'(2)) ? WIDTH'(2) : req_base;
          factor_d = WIDTH'(2);
          ovf_d    = 1'b0;
`ifdef PRIME_PAIR_EN
          phase_d  = 1'b0;
`endif
          state_d  = TEST;
        end
      end
      TEST: begin
`ifdef PRIME_PAIR_EN
        if (partner_wide[WIDTH]) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else
`endif
        if (factor_sq > bound) begin
          state_d = DONE;
        end else begin
          mod_start = 1'b1;
          state_d   = MOD_WAIT;
        end
      end
      MOD_WAIT: begin
        if (mod_done) begin
`ifdef PRIME_PAIR_EN
          if (witness) begin
            phase_d = 1'b0;
            state_d = NEXT_CAND;
          end else if (!phase_q) begin
            phase_d      = 1'b1;
            mod_start    = 1'b1;
            mod_dividend = partner_wide[WIDTH-1:0];
          end else begin
            phase_d  = 1'b0;
            factor_d = factor_q + WIDTH'(1);
            state_d  = TEST;
          end
`else
          if (mod_rem == '0) begin
            state_d = NEXT_CAND;
          end else begin
            factor_d = factor_q + WIDTH'(1);
            state_d  = TEST;
          end
`endif
        end
      end
      NEXT_CAND: begin
        if (&cand_q) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          cand_d   = cand_q + WIDTH'(1);
          factor_d = WIDTH'(2);
          state_d  = TEST;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and result outputs decode directly from registered state.
  always_comb begin
    req_ready    = (state_q == IDLE);
    busy         = (state_q != IDLE);
    rsp_valid    = (state_q == DONE);
    rsp_overflow = (state_q == DONE) && ovf_q;
    rsp_prime    = ((state_q == DONE) && !ovf_q) ? cand_q : '0;
  end

endmodule

// File: doc/prime_search_ctrl.md
PRIME_SEARCH_CTRL -- requirements
Module: prime_search_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, candidate and prime width in bits (legal range 4..32).
REQ-002 SHALL have parameter OFFSET, default 2, the pair distance; it is used only when PRIME_PAIR_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a search request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-007 SHALL have port req_base, input, WIDTH bits: the lowest candidate to test.
REQ-008 SHALL have port rsp_valid, output, 1 bit: a result is held.
REQ-009 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port rsp_prime, output, WIDTH bits: the smallest qualifying prime that is >= base.
REQ-011 SHALL have port rsp_overflow, output, 1 bit: no qualifying prime exists below 2^WIDTH.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, TEST, MOD_WAIT, NEXT_CAND and DONE.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-015 SHALL, on acceptance, set cand=max(req_base,2) and factor=2, then go to TEST.
REQ-016 SHALL, in TEST: if factor*factor > cand (2*WIDTH-bit compare), declare cand prime and go to DONE; otherwise start the remainder unit with (cand, factor) and go to MOD_WAIT.
REQ-017 SHALL, in MOD_WAIT on the done pulse: if the remainder is 0, go to NEXT_CAND; otherwise increment factor and return to TEST.
REQ-018 SHALL, in NEXT_CAND: if cand is all ones, set the overflow flag and go to DONE; otherwise increment cand, reset factor to 2, and go to TEST.
REQ-019 SHALL, in DONE, hold rsp_valid=1 with stable rsp_prime and rsp_overflow until rsp_ready=1, then return to IDLE on the next cycle.
REQ-020 SHALL drive rsp_prime=0 whenever rsp_overflow=1.
REQ-021 SHALL ensure the remainder unit returns cand % factor exactly WIDTH cycles after its start, with no early termination.
REQ-022 SHALL ignore req_valid in all states other than IDLE; there is no queuing.
REQ-023 SHALL give base=2 the result 2 after exactly one TEST cycle, with no remainder operation.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE regardless of state, including mid-search and mid-MOD_WAIT.
REQ-025 SHALL reset outputs to req_ready=1, rsp_valid=0, rsp_prime=0, rsp_overflow=0 and busy=0.
REQ-026 SHALL abort any in-flight remainder operation on reset; no done pulse may leak into the next request.

Configuration
REQ-027 SHALL, when macro PRIME_PAIR_EN is defined, test partner=cand+OFFSET as well, using the same factor loop; the factor bound is taken from the partner.
REQ-028 SHALL, with PRIME_PAIR_EN defined, qualify cand only when both cand and partner have no factor in [2, sqrt]; cand+OFFSET >= 2^WIDTH is treated as overflow.
REQ-029 SHALL, with PRIME_PAIR_EN defined, report only the lower member in rsp_prime.
REQ-030 SHALL, without PRIME_PAIR_EN, do single-prime search only and contain no partner logic or OFFSET usage.

Structure
REQ-031 SHALL place the FSM state enum and the factor/square width function in package prime_search_pkg.
REQ-032 SHALL instantiate one sub-module, mod_iter: a restoring remainder unit, one bit per cycle, with ports start, dividend, divisor, done and rem.

Verification
REQ-033 SHALL cover: base=0 -> rsp_prime=2, rsp_overflow=0.
REQ-034 SHALL cover: base=14 -> rsp_prime=17; base=65521, WIDTH=16 -> rsp_prime=65521.
REQ-035 SHALL cover: base=65535, WIDTH=16 -> rsp_overflow=1, rsp_prime=0.
REQ-036 SHALL cover: PRIME_PAIR_EN, OFFSET=2, base=14 -> rsp_prime=17 (the pair 17,19); base=24 -> rsp_prime=29.
REQ-037 SHALL cover: rsp_ready held low for 20 cycles -> rsp_valid and rsp_prime stable, and req_ready=0 throughout.
REQ-038 SHALL cover: rst asserted in MOD_WAIT, then base=9 -> rsp_prime=11, with no stale result.
